// File: rtl/volume_meter.sv
// volume_meter: windowed peak detector driving a 16-segment thermometer bar.
// Each window of WINDOW samples is reduced to its peak; the peak above
// BASELINE is mapped to a level 0..16 and published for one cycle.
// Optional build macro VOLUME_METER_PEAK_HOLD_EN: the bar falls by at most
// one segment per window and rises instantly.
module volume_meter #(
  parameter int WINDOW   = 4000,
  parameter int BASELINE = 2048
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic [11:0] mic_in,
  input  logic        sample_valid,
  output logic [15:0] led_out,
  output logic [4:0]  level,
  output logic        level_valid
);

  localparam logic [15:0] LP_LAST = 16'(WINDOW - 1);
  localparam logic [11:0] LP_BASE = 12'(BASELINE);
  localparam bit          LP_W1   = (WINDOW == 1);

  typedef enum logic {
    ST_ACCUM  = 1'b0,
    ST_UPDATE = 1'b1
  } state_t;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [11:0] r_peak;
  logic [15:0] r_led;
  logic [4:0]  r_level;
  logic        r_level_valid;

  logic [11:0] w_diff;
  logic [10:0] w_amp;
  logic [4:0]  w_n;
  logic [4:0]  w_pub;
  logic [15:0] w_led;

  assign led_out     = r_led;
  assign level       = r_level;
  assign level_valid = r_level_valid;

  // Amplitude above the midpoint, clamped to 11 bits, and its raw level.
  always_comb begin
    w_diff = 12'd0;
    if (r_peak > LP_BASE) w_diff = r_peak - LP_BASE;
    w_amp = w_diff[11] ? 11'h7FF : w_diff[10:0];
    w_n   = (w_amp == 11'd0) ? 5'd0 : ({1'b0, w_amp[10:7]} + 5'd1);
  end

`ifdef VOLUME_METER_PEAK_HOLD_EN
  logic [4:0] w_dec;

  // Decay-limited level: never drop more than one segment per window.
  always_comb begin
    w_dec = (r_level == 5'd0) ? 5'd0 : (r_level - 5'd1);
    w_pub = (w_n > w_dec) ? w_n : w_dec;
  end
`else
  // Publish the raw window level directly.
  always_comb begin
    w_pub = w_n;
  end
`endif

  // Thermometer code: segment k lit iff k < level.
  always_comb begin
    w_led = 16'h0000;
    for (int k = 0; k < 16; k++) begin
      w_led[k] = (5'(k) < w_pub);
    end
  end

  // Window FSM: accumulate peak over WINDOW samples, then one publish cycle.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state       <= ST_ACCUM;
      r_cnt         <= 16'd0;
      r_peak        <= 12'd0;
      r_led         <= 16'h0000;
      r_level       <= 5'd0;
      r_level_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          r_level_valid <= 1'b0;
          if (sample_valid) begin
            if (mic_in > r_peak) r_peak <= mic_in;
            if (r_cnt == LP_LAST) begin
              r_cnt   <= 16'd0;
              r_state <= ST_UPDATE;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
        end
        ST_UPDATE: begin
          r_led         <= w_led;
          r_level       <= w_pub;
          r_level_valid <= 1'b1;
          if (sample_valid) begin
            // Sample arriving now opens the next window. With a one-sample
            // window it already completes that window, so publish it next.
            r_peak <= mic_in;
            if (LP_W1) begin
              r_cnt   <= 16'd0;
              r_state <= ST_UPDATE;
            end else begin
              r_cnt   <= 16'd1;
              r_state <= ST_ACCUM;
            end
          end else begin
            r_peak  <= 12'd0;
            r_cnt   <= 16'd0;
            r_state <= ST_ACCUM;
          end
        end
        default: begin
          r_state <= ST_ACCUM;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_volume_meter.sv
// Scoreboard bench for volume_meter: one instance with WINDOW=4, one with
// WINDOW=1. Drivers push hand-computed levels; monitors pop on level_valid.
module tb_volume_meter;

  logic        CLOCK = 1'b0;
  logic        RESET_N;
  logic [11:0] mic_a, mic_b;
  logic        sv_a, sv_b;
  logic [15:0] led_a, led_b;
  logic [4:0]  lvl_a, lvl_b;
  logic        lv_a, lv_b;

  int checks   = 0;
  int failures = 0;

  logic [4:0] q_a[$];
  logic [4:0] q_b[$];
  logic [4:0] prev_a, prev_b;

  always #5 CLOCK = ~CLOCK;

  volume_meter #(.WINDOW(4), .BASELINE(2048)) u_a (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .mic_in(mic_a), .sample_valid(sv_a),
    .led_out(led_a), .level(lvl_a), .level_valid(lv_a)
  );

  volume_meter #(.WINDOW(1), .BASELINE(2048)) u_b (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .mic_in(mic_b), .sample_valid(sv_b),
    .led_out(led_b), .level(lvl_b), .level_valid(lv_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] thermo(input logic [4:0] l);
    logic [15:0] t;
    t = 16'h0000;
    for (int k = 0; k < 16; k++) t[k] = (k < int'(l));
    return t;
  endfunction

  // Published level given the raw window level and the previous output.
  function automatic logic [4:0] pub(input logic [4:0] n, input logic [4:0] prev);
`ifdef VOLUME_METER_PEAK_HOLD_EN
    logic [4:0] d;
    d = (prev == 5'd0) ? 5'd0 : prev - 5'd1;
    return (n > d) ? n : d;
`else
    return n;
`endif
  endfunction

  task automatic expect_a(input logic [4:0] n);
    logic [4:0] e;
    e = pub(n, prev_a);
    q_a.push_back(e);
    prev_a = e;
  endtask

  task automatic expect_b(input logic [4:0] n);
    logic [4:0] e;
    e = pub(n, prev_b);
    q_b.push_back(e);
    prev_b = e;
  endtask

  task automatic drive_a(input logic [11:0] v);
    mic_a = v; sv_a = 1'b1;
    @(posedge CLOCK); #1;
    sv_a = 1'b0;
  endtask

  task automatic drive_b(input logic [11:0] v);
    mic_b = v; sv_b = 1'b1;
    @(posedge CLOCK); #1;
    sv_b = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLOCK);
    #1;
  endtask

  // Monitor A: compare each published result; between pulses outputs hold.
  initial begin : mon_a
    logic [4:0] last, e;
    last = 5'd0;
    forever begin
      @(negedge CLOCK);
      if (!RESET_N) begin
        q_a.delete();
        last = 5'd0;
      end else if (lv_a) begin
        if (q_a.size() == 0) begin
          check("a_unexpected_pulse", 32'd1, 32'd0);
        end else begin
          e = q_a.pop_front();
          check("a_level", 32'(lvl_a), 32'(e));
          check("a_led", 32'(led_a), 32'(thermo(e)));
          last = e;
        end
      end else begin
        check("a_hold_level", 32'(lvl_a), 32'(last));
        check("a_hold_led", 32'(led_a), 32'(thermo(last)));
      end
    end
  end

  // Monitor B: same for the one-sample-window instance.
  initial begin : mon_b
    logic [4:0] last, e;
    last = 5'd0;
    forever begin
      @(negedge CLOCK);
      if (!RESET_N) begin
        q_b.delete();
        last = 5'd0;
      end else if (lv_b) begin
        if (q_b.size() == 0) begin
          check("b_unexpected_pulse", 32'd1, 32'd0);
        end else begin
          e = q_b.pop_front();
          check("b_level", 32'(lvl_b), 32'(e));
          check("b_led", 32'(led_b), 32'(thermo(e)));
          last = e;
        end
      end else begin
        check("b_hold_level", 32'(lvl_b), 32'(last));
        check("b_hold_led", 32'(led_b), 32'(thermo(last)));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int wait_cnt;
    RESET_N = 1'b1;
    mic_a = 12'd0; sv_a = 1'b0;
    mic_b = 12'd0; sv_b = 1'b0;
    prev_a = 5'd0; prev_b = 5'd0;
    #1 RESET_N = 1'b0;
    #2;
    check("rst_led_a", 32'(led_a), 32'h0);
    check("rst_level_a", 32'(lvl_a), 32'd0);
    check("rst_valid_a", 32'(lv_a), 32'd0);
    check("rst_led_b", 32'(led_b), 32'h0);
    check("rst_valid_b", 32'(lv_b), 32'd0);
    repeat (3) @(posedge CLOCK);
    #1 RESET_N = 1'b1;
    idle(2);

    // Peak 3000 -> a=952 -> level 8, with exact pulse timing.
    expect_a(5'd8);
    drive_a(12'd2048); drive_a(12'd2100); drive_a(12'd3000); drive_a(12'd2200);
    check("t1_valid_in_update", 32'(lv_a), 32'd0);
    @(posedge CLOCK); #1;
    check("t1_valid_pulse", 32'(lv_a), 32'd1);
    check("t1_led", 32'(led_a), 32'h00FF);
    @(posedge CLOCK); #1;
    check("t1_valid_end", 32'(lv_a), 32'd0);
    idle(2);

    // Full scale, then a quiet window below the midpoint.
    expect_a(5'd16);
    drive_a(12'd4095); drive_a(12'd4095); drive_a(12'd4095); drive_a(12'd4095);
    idle(3);
    expect_a(5'd0);
    drive_a(12'd1000); drive_a(12'd1000); drive_a(12'd1000); drive_a(12'd1000);
    idle(3);

    // Segment boundaries: a=128 -> 2, a=127 -> 1.
    expect_a(5'd2);
    drive_a(12'd2176); drive_a(12'd0); drive_a(12'd100); drive_a(12'd2000);
    idle(3);
    expect_a(5'd1);
    drive_a(12'd2175); drive_a(12'd2175); drive_a(12'd2049); drive_a(12'd0);
    idle(3);

    // Sample in the UPDATE cycle seeds the next window.
    expect_a(5'd0);
    expect_a(5'd16);
    drive_a(12'd2048); drive_a(12'd2048); drive_a(12'd2048); drive_a(12'd2048);
    drive_a(12'd4000);
    drive_a(12'd2048); drive_a(12'd2048); drive_a(12'd2048);
    idle(3);

    // One-sample window, continuous valid: 2049 -> 1, 2048 -> 0, 2300 -> 2.
    expect_b(5'd1);
    expect_b(5'd0);
    expect_b(5'd2);
    drive_b(12'd2049); drive_b(12'd2048); drive_b(12'd2300);
    idle(4);

    // Reset mid-window discards the partial window and clears outputs.
    drive_a(12'd4095); drive_a(12'd4095);
    #2 RESET_N = 1'b0;
    #1;
    check("midrst_led_a", 32'(led_a), 32'h0);
    check("midrst_level_a", 32'(lvl_a), 32'd0);
    check("midrst_valid_a", 32'(lv_a), 32'd0);
    check("midrst_led_b", 32'(led_b), 32'h0);
    check("midrst_level_b", 32'(lvl_b), 32'd0);
    repeat (2) @(posedge CLOCK);
    #1 RESET_N = 1'b1;
    prev_a = 5'd0; prev_b = 5'd0;
    idle(1);
    expect_a(5'd0);
    drive_a(12'd2048); drive_a(12'd2048); drive_a(12'd2048); drive_a(12'd2048);
    idle(4);

    wait_cnt = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && wait_cnt < 50) begin
      @(posedge CLOCK);
      wait_cnt++;
    end
    #1;
    check("a_queue_drained", 32'(q_a.size()), 32'd0);
    check("b_queue_drained", 32'(q_b.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
